// File: rtl/mcycle_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit: FSM state
// encoding, operation codes and the default operand width.
package mcycle_pkg;

    localparam int MCYCLE_WIDTH = 32;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COMPUTING = 2'd1,
        ST_DONE      = 2'd2
    } mcycle_state_e;

endpackage

// File: rtl/mcycle_sign_fix.sv
// Sign handling for the multi-cycle unit. Produces operand magnitudes for the
// unsigned iteration datapath and applies the sign correction to the raw
// iteration result. Divide-by-zero results are also formed here because they
// depend on the original (unsigned-converted) dividend.
module mcycle_sign_fix
    import mcycle_pkg::*;
#(
    parameter int WIDTH = MCYCLE_WIDTH
) (
    input  logic             i_signed,
    input  logic             i_op,
    input  logic [WIDTH-1:0] i_op1,
    input  logic [WIDTH-1:0] i_op2,
    input  logic [WIDTH-1:0] i_raw_lo,
    input  logic [WIDTH-1:0] i_raw_hi,
    output logic [WIDTH-1:0] o_abs1,
    output logic [WIDTH-1:0] o_abs2,
    output logic [WIDTH-1:0] o_res1,
    output logic [WIDTH-1:0] o_res2
);

    logic                 w_neg1;
    logic                 w_neg2;
    logic                 w_div_zero;
    logic [2*WIDTH-1:0]   w_prod;
    logic [2*WIDTH-1:0]   w_prod_neg;

    assign w_neg1     = i_signed & i_op1[WIDTH-1];
    assign w_neg2     = i_signed & i_op2[WIDTH-1];
    assign w_div_zero = (i_op2 == '0);

    // Magnitudes; the most-negative value maps to itself, which is the
    // correct unsigned magnitude.
    assign o_abs1 = w_neg1 ? -i_op1 : i_op1;
    assign o_abs2 = w_neg2 ? -i_op2 : i_op2;

    assign w_prod     = {i_raw_hi, i_raw_lo};
    assign w_prod_neg = -w_prod;

    // Result sign correction: product negated as a whole; quotient takes the
    // xor of operand signs, remainder takes the dividend sign.
    always_comb begin
        o_res1 = '0;
        o_res2 = '0;
        if (i_op == OP_MUL) begin
            {o_res2, o_res1} = (w_neg1 ^ w_neg2) ? w_prod_neg : w_prod;
        end else if (w_div_zero) begin
            o_res1 = '1;
            o_res2 = i_op1;
        end else begin
            o_res1 = (w_neg1 ^ w_neg2) ? -i_raw_lo : i_raw_lo;
            o_res2 = w_neg1 ? -i_raw_hi : i_raw_hi;
        end
    end

endmodule

// File: rtl/mcycle_unit.sv
// Multi-cycle multiply/divide unit. One shift-add (multiply) or restoring
// shift-subtract (divide) iteration per cycle, followed by one sign-fix cycle
// that writes the results and enters DONE.
// Optional feature: define MCYCLE_DIV_EN to include the divide datapath;
// without it a divide request completes immediately with zero results.
// Handshake: Start is a request sampled only in IDLE; Busy is high in the
// requesting cycle and throughout COMPUTING; Done pulses for one cycle.
module mcycle_unit
    import mcycle_pkg::*;
#(
    parameter int WIDTH = MCYCLE_WIDTH
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              Start,
    input  logic              MCycleOp,
    input  logic              Signed,
    input  logic [WIDTH-1:0]  Operand1,
    input  logic [WIDTH-1:0]  Operand2,
    output logic [WIDTH-1:0]  Result1,
    output logic [WIDTH-1:0]  Result2,
    output logic              Busy,
    output logic              Done,
    output mcycle_state_e     o_dbg_state
);

    localparam int            CW        = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH);

    mcycle_state_e        r_state;
    mcycle_state_e        w_next_state;

    logic                 r_op;
    logic                 r_signed;
    logic [WIDTH-1:0]     r_op1;
    logic [WIDTH-1:0]     r_op2;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_prod;
    logic [WIDTH-1:0]     r_res1;
    logic [WIDTH-1:0]     r_res2;

    logic [WIDTH-1:0]     w_abs1;
    logic [WIDTH-1:0]     w_abs2;
    logic [WIDTH-1:0]     w_fix_res1;
    logic [WIDTH-1:0]     w_fix_res2;
    logic [2*WIDTH-1:0]   w_cur;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [2*WIDTH-1:0]   w_iter_next;

    mcycle_sign_fix #(
        .WIDTH    (WIDTH)
    ) u_sign_fix (
        .i_signed (r_signed),
        .i_op     (r_op),
        .i_op1    (r_op1),
        .i_op2    (r_op2),
        .i_raw_lo (r_prod[WIDTH-1:0]),
        .i_raw_hi (r_prod[2*WIDTH-1:WIDTH]),
        .o_abs1   (w_abs1),
        .o_abs2   (w_abs2),
        .o_res1   (w_fix_res1),
        .o_res2   (w_fix_res2)
    );

    // Working register seed on the first iteration: upper half cleared,
    // lower half holds the multiplier (multiply) or dividend (divide).
    assign w_cur = (r_cnt == '0)
                 ? {{WIDTH{1'b0}}, ((r_op == OP_MUL) ? w_abs2 : w_abs1)}
                 : r_prod;

    // Shift-add: conditionally add multiplicand to the upper half, then
    // shift the whole register right, consuming one multiplier bit.
    assign w_mul_sum  = {1'b0, w_cur[2*WIDTH-1:WIDTH]}
                      + (w_cur[0] ? {1'b0, w_abs1} : {(WIDTH+1){1'b0}});
    assign w_mul_next = {w_mul_sum, w_cur[WIDTH-1:1]};

`ifdef MCYCLE_DIV_EN
    logic [WIDTH:0]       w_div_shift;
    logic [WIDTH-1:0]     w_div_diff;
    logic                 w_div_ge;
    logic [2*WIDTH-1:0]   w_div_next;

    // Restoring divide: upper half is the partial remainder, lower half
    // shifts out dividend bits and shifts in quotient bits.
    assign w_div_shift = {w_cur[2*WIDTH-1:WIDTH], w_cur[WIDTH-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, w_abs2});
    assign w_div_diff  = w_div_shift[WIDTH-1:0] - w_abs2;
    assign w_div_next  = w_div_ge
                       ? {w_div_diff, w_cur[WIDTH-2:0], 1'b1}
                       : {w_div_shift[WIDTH-1:0], w_cur[WIDTH-2:0], 1'b0};
    assign w_iter_next = (r_op == OP_DIV) ? w_div_next : w_mul_next;
`else
    assign w_iter_next = w_mul_next;
`endif

    // State register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; COMPUTING lasts WIDTH iterations plus the sign-fix cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (Start) begin
`ifdef MCYCLE_DIV_EN
                    w_next_state = ST_COMPUTING;
`else
                    w_next_state = (MCycleOp == OP_DIV) ? ST_DONE : ST_COMPUTING;
`endif
                end
            end
            ST_COMPUTING: begin
                if (r_cnt == LAST_ITER) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Outputs: Busy stalls the requesting cycle too, Done is the DONE state.
    always_comb begin
        Busy = ((r_state == ST_IDLE) && Start) || (r_state == ST_COMPUTING);
        Done = (r_state == ST_DONE);
    end

    // Datapath: latch request, iterate, then write sign-corrected results.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_op     <= 1'b0;
            r_signed <= 1'b0;
            r_op1    <= '0;
            r_op2    <= '0;
            r_cnt    <= '0;
            r_prod   <= '0;
            r_res1   <= '0;
            r_res2   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (Start) begin
                        r_op     <= MCycleOp;
                        r_signed <= Signed;
                        r_op1    <= Operand1;
                        r_op2    <= Operand2;
                        r_cnt    <= '0;
`ifndef MCYCLE_DIV_EN
                        if (MCycleOp == OP_DIV) begin
                            r_res1 <= '0;
                            r_res2 <= '0;
                        end
`endif
                    end
                end
                ST_COMPUTING: begin
                    if (r_cnt != LAST_ITER) begin
                        r_prod <= w_iter_next;
                        r_cnt  <= r_cnt + 1'b1;
                    end else begin
                        r_res1 <= w_fix_res1;
                        r_res2 <= w_fix_res2;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign Result1     = r_res1;
    assign Result2     = r_res2;
    assign o_dbg_state = r_state;

endmodule

// File: doc/mcycle_unit.md
MCYCLE_UNIT -- requirements
Module: mcycle_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port RESET_N  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port Start  input  1  request new operation, sampled in IDLE only.
REQ-005 SHALL have port MCycleOp  input  1  0 = multiply, 1 = divide.
REQ-006 SHALL have port Signed  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-007 SHALL have port Operand1  input  WIDTH  multiplicand/dividend (Rm via shifter pass-through).
REQ-008 SHALL have port Operand2  input  WIDTH  multiplier/divisor (Rs).
REQ-009 SHALL have port Result1  output  WIDTH  product low word / quotient.
REQ-010 SHALL have port Result2  output  WIDTH  product high word / remainder.
REQ-011 SHALL have port Busy  output  1  pipeline stall request.
REQ-012 SHALL have port Done  output  1  one-cycle completion pulse.

Function
REQ-013 SHALL implement states IDLE, COMPUTING, DONE; IDLE->COMPUTING on Start, COMPUTING->DONE after WIDTH iterations, DONE->IDLE unconditionally.
REQ-014 SHALL latch MCycleOp, Signed, Operand1, Operand2 on the edge where Start is sampled in IDLE; later input changes ignored until next operation.
REQ-015 SHALL drive Busy combinationally = (state==IDLE & Start) | (state==COMPUTING), so the requesting cycle already stalls.
REQ-016 SHALL perform one iteration per cycle (shift-add multiply, restoring shift-subtract divide); Start sampled at edge k -> Done=1 in cycle after edge k+WIDTH+1, Busy=0 in that cycle.
REQ-017 SHALL assert Done for exactly one cycle (DONE state) and update Result1/Result2 on the same edge that enters DONE.
REQ-018 SHALL hold Result1/Result2 stable from DONE until the next operation completes.
REQ-019 SHALL ignore Start while COMPUTING or DONE; Start in DONE is not queued.
REQ-020 Multiply SHALL produce the full 2*WIDTH-bit product: Result2 high, Result1 low.
REQ-021 Signed multiply/divide SHALL operate on magnitudes and correct signs after; quotient truncates toward zero, remainder takes dividend sign.
REQ-022 Divide by zero SHALL give Result1 = all ones, Result2 = Operand1, with normal latency.
REQ-023 Signed divide of most-negative by -1 SHALL give Result1 = most-negative, Result2 = 0.

Reset
REQ-024 RESET_N low SHALL immediately force state IDLE, Result1=0, Result2=0, Done=0, internal registers 0, regardless of clock.
REQ-025 Reset mid-operation SHALL abandon the operation; Busy follows REQ-015 from IDLE once RESET_N rises.

Configuration
REQ-026 Macro MCYCLE_DIV_EN defined SHALL include divide datapath per REQ-016/021-023.
REQ-027 Macro MCYCLE_DIV_EN undefined SHALL omit divide logic; MCycleOp=1 Start goes IDLE->DONE in one edge, Result1=Result2=0, Busy high only in the Start cycle.

Structure
REQ-028 Shared package mcycle_pkg SHALL hold state encoding, MCycleOp codes (OP_MUL, OP_DIV), default WIDTH.
REQ-029 Sign handling SHALL be sub-module mcycle_sign_fix (combinational abs of operands, negate of results); iteration datapath and FSM stay in mcycle_unit.

Verification
REQ-030 Unsigned mul 0xFFFFFFFF*0xFFFFFFFF -> Result1=0x00000001, Result2=0xFFFFFFFE, Done exactly 33 edges after Start edge, Busy high in the Start cycle and all COMPUTING cycles.
REQ-031 Signed mul -2*3 -> Result1=0xFFFFFFFA, Result2=0xFFFFFFFF; same as unsigned mul 0xFFFFFFFE*3 -> Result1=0xFFFFFFFA, Result2=0x00000002.
REQ-032 Unsigned div 100/7 -> Result1=14, Result2=2; signed div -7/2 -> Result1=0xFFFFFFFD, Result2=0xFFFFFFFF.
REQ-033 Div 5/0 -> Result1=0xFFFFFFFF, Result2=5; signed 0x80000000/-1 -> Result1=0x80000000, Result2=0.
REQ-034 Start pulsed during COMPUTING with changed operands -> original result returned, no second Done; RESET_N low at iteration 10 -> Done=0, Results=0, Busy=0 immediately.
REQ-035 Build without MCYCLE_DIV_EN: div 100/7 -> Done one edge after Start, Result1=Result2=0; mul regression REQ-030 unchanged.
